head_wr_sched: RTL and testbench

Write scheduler for the hash table's head RAM write port. Arbitrates bucket-head updates from up to `NUM_REQ` engines (insert, delete, maintenance) onto the single head-table write port. Also sequences a full-RAM clear that zeroes every bucket pointer. Sits between the update engines and the head table's write interface; the read path is untouched.

---
 rtl/head_wr_sched_pkg.sv | 26 ++
 rtl/head_wr_sched_rr_arbiter.sv | 68 ++++++
 rtl/head_wr_sched.sv | 162 ++++++++++++++++
 tb/tb_head_wr_sched.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/head_wr_sched_pkg.sv
// Shared types for the hash table head RAM write path: default widths,
// head RAM word layout, per-requester write fields and scheduler states.
package hash_table;

  localparam int BUCKET_WIDTH   = 4;
  localparam int HEAD_PTR_WIDTH = 8;

  // One head RAM word: bucket head pointer plus its valid flag.
  typedef struct packed {
    logic [HEAD_PTR_WIDTH-1:0] ptr;
    logic                      ptr_val;
  } head_ram_data_t;

  // Fields carried by one requester slot at the default widths.
  typedef struct packed {
    logic [BUCKET_WIDTH-1:0]   addr;
    logic [HEAD_PTR_WIDTH-1:0] ptr;
    logic                      ptr_val;
  } head_wr_req_t;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } head_wr_sched_state_t;

endpackage

// File: rtl/head_wr_sched_rr_arbiter.sv
// rr_arbiter: one-hot grant among N valid requesters.
// Default build: round-robin, the pointer moves past the winner on a grant.
// With HEAD_WR_SCHED_FIXED_PRIO_EN defined: lowest asserted index wins and
// no pointer state exists.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] valid,
  output logic [N-1:0] grant
);

`ifdef HEAD_WR_SCHED_FIXED_PRIO_EN

  logic found;

  // Lowest asserted index wins whenever arbitration is enabled.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (en && valid[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

`else

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] ptr_next;
  logic          found;

  // Search from the pointer upward modulo N; first asserted valid wins and
  // the pointer moves to the slot just after the winner.
  always_comb begin : search
    int idx;
    grant    = '0;
    found    = 1'b0;
    ptr_next = ptr_reg;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_reg) + i;
      if (idx >= N) idx = idx - N;
      if (en && !found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        ptr_next   = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  // Priority pointer register; holds when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

`endif

endmodule

// File: rtl/head_wr_sched.sv
// head_wr_sched: arbitrates bucket-head updates from NUM_REQ engines onto the
// single head RAM write port, and sequences a full-RAM clear that writes zero
// to every address. Optional build macro HEAD_WR_SCHED_FIXED_PRIO_EN selects
// fixed-priority arbitration instead of round-robin.
module head_wr_sched
  import hash_table::*;
#(
  parameter int NUM_REQ = 4,
  parameter int A_WIDTH = BUCKET_WIDTH,
  parameter int P_WIDTH = HEAD_PTR_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*P_WIDTH-1:0] req_ptr_i,
  input  logic [NUM_REQ-1:0]         req_ptr_val_i,
  output logic                       wr_en_o,
  output logic [A_WIDTH-1:0]         wr_addr_o,
  output logic [P_WIDTH-1:0]         wr_data_ptr_o,
  output logic                       wr_data_ptr_val_o,
  input  logic                       clear_run_i,
  output logic                       clear_done_o,
  output logic                       busy_o
);

  head_wr_sched_state_t state_reg;
  head_wr_sched_state_t state_next;

  logic [A_WIDTH-1:0] clr_addr_reg;
  logic [A_WIDTH-1:0] clr_addr_next;
  logic               clr_last;
  logic               in_clear;
  logic               arb_en;

  logic [NUM_REQ-1:0] grant;

  logic [A_WIDTH-1:0] slot_addr [NUM_REQ];
  logic [P_WIDTH-1:0] slot_ptr  [NUM_REQ];
  logic               slot_val  [NUM_REQ];

  logic [A_WIDTH-1:0] sel_addr;
  logic [P_WIDTH-1:0] sel_ptr;
  logic               sel_val;

  logic               wr_en_reg;
  logic [A_WIDTH-1:0] wr_addr_reg;
  logic [P_WIDTH-1:0] wr_ptr_reg;
  logic               wr_val_reg;

  assign in_clear = (state_reg == CLEAR);
  assign clr_last = &clr_addr_reg;

  // Arbitration is only live in RUN on cycles without a clear request, and
  // never while reset is held so no grant leaks out during reset.
  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .en    (arb_en && rst_n_i),
    .valid (req_valid_i),
    .grant (grant)
  );

  assign req_ready_o = grant;

  // Each slot contributes its fields only when it holds the grant, so the
  // winner can be picked with a plain OR across slots.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      assign slot_addr[gi] = grant[gi] ? req_addr_i[gi*A_WIDTH +: A_WIDTH] : '0;
      assign slot_ptr[gi]  = grant[gi] ? req_ptr_i[gi*P_WIDTH +: P_WIDTH]  : '0;
      assign slot_val[gi]  = grant[gi] & req_ptr_val_i[gi];
    end
  endgenerate

  // OR-reduce the masked slot fields into the granted request.
  always_comb begin
    sel_addr = '0;
    sel_ptr  = '0;
    sel_val  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr = sel_addr | slot_addr[i];
      sel_ptr  = sel_ptr  | slot_ptr[i];
      sel_val  = sel_val  | slot_val[i];
    end
  end

  // State and clear counter registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg    <= RUN;
      clr_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
    end
  end

  // Next state and clear walk: a clear request always (re)starts at address
  // 0; the walk leaves CLEAR after writing the all-ones address.
  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    arb_en        = 1'b0;
    case (state_reg)
      RUN: begin
        if (clear_run_i) begin
          state_next    = CLEAR;
          clr_addr_next = '0;
        end else begin
          arb_en = 1'b1;
        end
      end
      CLEAR: begin
        if (clear_run_i) begin
          clr_addr_next = '0;
        end else if (clr_last) begin
          state_next    = RUN;
          clr_addr_next = '0;
        end else begin
          clr_addr_next = clr_addr_reg + A_WIDTH'(1);
        end
      end
      default: begin
        state_next    = RUN;
        clr_addr_next = '0;
      end
    endcase
  end

  // Output register for granted writes: one cycle of wr_en per handshake,
  // data held between writes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_ptr_reg  <= '0;
      wr_val_reg  <= 1'b0;
    end else begin
      wr_en_reg <= |grant;
      if (|grant) begin
        wr_addr_reg <= sel_addr;
        wr_ptr_reg  <= sel_ptr;
        wr_val_reg  <= sel_val;
      end
    end
  end

  // During CLEAR the write port shows the walk address with zero data; no
  // grant can be pending then, so the registered write is idle.
  assign wr_en_o           = in_clear | wr_en_reg;
  assign wr_addr_o         = in_clear ? clr_addr_reg : wr_addr_reg;
  assign wr_data_ptr_o     = in_clear ? '0 : wr_ptr_reg;
  assign wr_data_ptr_val_o = in_clear ? 1'b0 : wr_val_reg;
  assign clear_done_o      = in_clear & clr_last;
  assign busy_o            = in_clear;

endmodule

// File: tb/tb_head_wr_sched.sv
// Self-checking bench for head_wr_sched (NUM_REQ=4, A_WIDTH=4, P_WIDTH=8).
// A transaction-level model tracks the priority pointer, the clear walk and
// the write expected on the port each cycle.
module tb_head_wr_sched;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int PW = 8;
  localparam int VW = N + 1 + AW + PW + 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    valid = '0;
  logic [N-1:0]    ready;
  logic [N*AW-1:0] addr_bus = '0;
  logic [N*PW-1:0] ptr_bus = '0;
  logic [N-1:0]    pval = '0;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [PW-1:0]   wr_ptr;
  logic            wr_val;
  logic            clear_run = 1'b0;
  logic            clear_done;
  logic            busy;

  int errors = 0;
  int checks = 0;

  // model of the scheduler at transaction level
  int          m_ptr;
  bit          m_clr;
  int          m_idx;
  bit          m_wen;
  logic [AW-1:0] m_waddr;
  logic [PW-1:0] m_wptr;
  logic          m_wval;

  always #5 clk = ~clk;

  head_wr_sched #(.NUM_REQ(N), .A_WIDTH(AW), .P_WIDTH(PW)) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .req_valid_i       (valid),
    .req_ready_o       (ready),
    .req_addr_i        (addr_bus),
    .req_ptr_i         (ptr_bus),
    .req_ptr_val_i     (pval),
    .wr_en_o           (wr_en),
    .wr_addr_o         (wr_addr),
    .wr_data_ptr_o     (wr_ptr),
    .wr_data_ptr_val_o (wr_val),
    .clear_run_i       (clear_run),
    .clear_done_o      (clear_done),
    .busy_o            (busy)
  );

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] g;
    int k;
    g = '0;
    if (!rst_n || m_clr || clear_run) return g;
    for (int i = 0; i < N; i++) begin
`ifdef HEAD_WR_SCHED_FIXED_PRIO_EN
      k = i;
`else
      k = (m_ptr + i) % N;
`endif
      if (valid[k]) begin
        g[k] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [AW-1:0] a;
    if (m_clr) begin
      a = AW'(m_idx);
      return {model_ready(), 1'b1, a, PW'(0), 1'b0, (m_idx == (1 << AW) - 1), 1'b1};
    end
    if (m_wen) return {model_ready(), 1'b1, m_waddr, m_wptr, m_wval, 1'b0, 1'b0};
    return {model_ready(), 1'b0, AW'(0), PW'(0), 1'b0, 1'b0, 1'b0};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    if (wr_en) return {ready, wr_en, wr_addr, wr_ptr, wr_val, clear_done, busy};
    return {ready, wr_en, AW'(0), PW'(0), 1'b0, clear_done, busy};
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_clr = 0; m_idx = 0; m_wen = 0;
    m_waddr = '0; m_wptr = '0; m_wval = 1'b0;
  endtask

  // advance the model by one clock using the inputs currently applied
  task automatic model_step();
    logic [N-1:0] g;
    g = model_ready();
    if (!rst_n) return;
    m_wen = 0;
    if (clear_run) begin
      m_clr = 1; m_idx = 0;
    end else if (m_clr) begin
      if (m_idx == (1 << AW) - 1) m_clr = 0;
      else m_idx++;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (g[k]) begin
          m_wen   = 1;
          m_waddr = addr_bus[k*AW +: AW];
          m_wptr  = ptr_bus[k*PW +: PW];
          m_wval  = pval[k];
          m_ptr   = (k + 1) % N;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs(input logic [N-1:0] v, input logic c);
    valid     = v;
    clear_run = c;
    addr_bus  = (N*AW)'($urandom);
    ptr_bus   = (N*PW)'($urandom);
    pval      = N'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid = '0; clear_run = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (obs_vec() !== {VW{1'b0}}) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", obs_vec(), {VW{1'b0}});
    end else $display("reset_state ok");
  endtask

  task automatic test_single();
    valid = 4'b0100; clear_run = 1'b0;
    addr_bus = '0; ptr_bus = '0; pval = 4'b0100;
    addr_bus[2*AW +: AW] = 4'd5;
    ptr_bus[2*PW +: PW]  = 8'd9;
    #1;
    checks++;
    if (ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_ready: got %b want %b", ready, 4'b0100);
    end
    tick();
    valid = '0;
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_ptr, wr_val} !== {1'b1, 4'd5, 8'd9, 1'b1}) begin
      errors++;
      $display("FAIL single_write: got en=%b addr=%0d ptr=%0d val=%b want en=1 addr=5 ptr=9 val=1",
               wr_en, wr_addr, wr_ptr, wr_val);
    end else $display("single write addr=%0d ptr=%0d", wr_addr, wr_ptr);
    tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] want;
    int wr_run;
    do_reset();
    wr_run = 0;
    for (int i = 0; i < 10; i++) begin
      rand_inputs((i < 8) ? 4'hF : 4'h0, 1'b0);
      #1;
`ifdef HEAD_WR_SCHED_FIXED_PRIO_EN
      want = 4'b0001;
`else
      want = 4'b0001 << (i % N);
`endif
      if (i < 8) begin
        checks++;
        if (ready !== want) begin
          errors++;
          $display("FAIL rr_grant[%0d]: got %b want %b", i, ready, want);
        end else $display("rr cycle %0d grant %b", i, ready);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rr_port[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (wr_en) wr_run++;
      tick();
    end
    #1;
    if (wr_en) wr_run++;
    checks++;
    if (wr_run !== 8) begin
      errors++;
      $display("FAIL rr_write_count: got %0d want 8", wr_run);
    end
  endtask

  task automatic test_clear();
    int zero_ready, dones;
    zero_ready = 0; dones = 0;
    for (int i = 0; i < 22; i++) begin
      rand_inputs(4'hF, i == 2);
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL clear_port[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end else $display("clear cycle %0d en=%b addr=%0d done=%b", i, wr_en, wr_addr, clear_done);
      if (i >= 2 && ready == '0) zero_ready++;
      if (clear_done) dones++;
      tick();
    end
    checks++;
    if (zero_ready !== 17 || dones !== 1) begin
      errors++;
      $display("FAIL clear_summary: got ready_low=%0d done=%0d want 17 and 1", zero_ready, dones);
    end
  endtask

  task automatic test_clear_restart();
    int dones;
    bit restarted, c;
    dones = 0; restarted = 0;
    for (int i = 0; i < 40; i++) begin
      c = (i == 0) || (m_clr && m_idx == 7 && !restarted);
      if (i != 0 && c) restarted = 1;
      rand_inputs(4'($urandom), c);
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL restart_port[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (clear_done) dones++;
      tick();
    end
    checks++;
    if (dones !== 1 || !restarted) begin
      errors++;
      $display("FAIL restart_done_count: got %0d want 1", dones);
    end else $display("clear restart done pulses=%0d", dones);
  endtask

  task automatic test_reset_mid_clear();
    int dones;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      rand_inputs(4'hF, i == 0);
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL midrst_port[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (clear_done) dones++;
      if (i < 4) tick();
    end
    // now in the cycle writing address 3
    checks++;
    if (!(busy && wr_addr == 4'd3)) begin
      errors++;
      $display("FAIL midrst_addr: got busy=%b addr=%0d want busy=1 addr=3", busy, wr_addr);
    end
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== {VW{1'b0}}) begin
      errors++;
      $display("FAIL midrst_async: got %h want %h", obs_vec(), {VW{1'b0}});
    end else $display("reset mid-clear outputs cleared");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_inputs((i == 0) ? 4'b0010 : 4'b0000, 1'b0);
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL midrst_after[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == 0) begin
        checks++;
        if (ready !== 4'b0010) begin
          errors++;
          $display("FAIL midrst_grant: got %b want %b", ready, 4'b0010);
        end
      end
      if (clear_done) dones++;
      tick();
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL midrst_done: got %0d want 0", dones);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_inputs(4'($urandom), ($urandom_range(0, 49) == 0));
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_port[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end else if (wr_en) $display("rand %0d wr addr=%0d ptr=%0d val=%b busy=%b", i, wr_addr, wr_ptr, wr_val, busy);
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_clear();
    test_clear_restart();
    test_reset_mid_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
